// File: rtl/sc1_cpu.sv
// sc1_cpu -- small non-pipelined 32-bit CPU.
//
// Each instruction runs FETCH -> DECODE -> EXEC -> FETCH (3 clk). LD adds
// a MEM state after EXEC (4 clk). HALT parks the core in HALTED until reset.
//
// Ports:
//   clk       in   1   single clock, rising edge
//   reset     in   1   asynchronous, active-low reset
//   rom_addr  out  8   instruction fetch address (= PC)
//   rom_data  in  32   instruction word, valid one clk after rom_addr
//   port_in   in  32   general input port, sampled by IN
//   port_out  out 32   registered output port, written by OUT
//
// Parameter:
//   DMEM_AW   data-memory address width (2^DMEM_AW words of 32 bits)
//
// Build option:
//   SC1_CPU_MUL_EN  when defined, opcode 18 is MUL (rd = low 32 bits of
//                   ra*rb); otherwise opcode 18 is a NOP and no multiplier
//                   is built.

// Synchronous single-port data RAM: write and read both on the rising edge.
module sc1_cpu_dram #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);
  localparam int DEPTH = 2 ** AW;

  logic [31:0] mem_q [0:DEPTH-1];

  // Write port plus registered read of the addressed word.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_o <= mem_q[addr_i];
  end
endmodule

module sc1_cpu #(
  parameter int DMEM_AW = 8
) (
  input  logic        clk,
  input  logic        reset,
  output logic [7:0]  rom_addr,
  input  logic [31:0] rom_data,
  input  logic [31:0] port_in,
  output logic [31:0] port_out
);

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_HALTED = 3'd4
  } state_t;

  localparam logic [4:0] OP_NOP  = 5'd0;
  localparam logic [4:0] OP_LDI  = 5'd1;
  localparam logic [4:0] OP_LDIH = 5'd2;
  localparam logic [4:0] OP_ADD  = 5'd3;
  localparam logic [4:0] OP_SUB  = 5'd4;
  localparam logic [4:0] OP_AND  = 5'd5;
  localparam logic [4:0] OP_OR   = 5'd6;
  localparam logic [4:0] OP_XOR  = 5'd7;
  localparam logic [4:0] OP_ADDI = 5'd8;
  localparam logic [4:0] OP_SHL  = 5'd9;
  localparam logic [4:0] OP_SHR  = 5'd10;
  localparam logic [4:0] OP_LD   = 5'd11;
  localparam logic [4:0] OP_ST   = 5'd12;
  localparam logic [4:0] OP_IN   = 5'd13;
  localparam logic [4:0] OP_OUT  = 5'd14;
  localparam logic [4:0] OP_JMP  = 5'd15;
  localparam logic [4:0] OP_BZ   = 5'd16;
  localparam logic [4:0] OP_BNZ  = 5'd17;
  localparam logic [4:0] OP_MUL  = 5'd18;
  localparam logic [4:0] OP_HALT = 5'd31;

  state_t      state_q;
  logic [7:0]  pc_q;
  logic [7:0]  pc_d;
  logic [31:0] ir_q;
  logic [31:0] port_out_q;
  logic [31:0] reg_file [16];

  // Instruction fields.
  logic [4:0]  op_s;
  logic [3:0]  d_s;
  logic [3:0]  a_s;
  logic [3:0]  b_s;
  logic [15:0] imm_s;
  logic [31:0] rd_s;
  logic [31:0] ra_s;
  logic [31:0] rb_s;

  assign op_s  = ir_q[31:27];
  assign d_s   = ir_q[23:20];
  assign a_s   = ir_q[19:16];
  assign b_s   = ir_q[15:12];
  assign imm_s = ir_q[15:0];
  assign rd_s  = reg_file[d_s];
  assign ra_s  = reg_file[a_s];
  assign rb_s  = reg_file[b_s];

  // Bits [26:24] carry no meaning in any opcode.
  logic unused_ir_s;
  assign unused_ir_s = ^ir_q[26:24];

  // Execute-stage decisions, applied only while in EXEC.
  logic        wb_en_s;
  logic [31:0] wb_data_s;
  logic        is_ld_s;
  logic        is_st_s;
  logic        is_out_s;
  logic        is_halt_s;

  // Data RAM hookup: ST writes at the end of EXEC; LD reads the addressed
  // word at the end of EXEC and commits it in MEM.
  logic        ram_we_s;
  logic [31:0] ram_rdata_s;

  assign ram_we_s = (state_q == ST_EXEC) && is_st_s;

  sc1_cpu_dram #(.AW(DMEM_AW)) mem_d_a (
    .clk     (clk),
    .we_i    (ram_we_s),
    .addr_i  (ra_s[DMEM_AW-1:0]),
    .wdata_i (rd_s),
    .rdata_o (ram_rdata_s)
  );

  // Opcode decode: ALU result, write-back enable, next PC and side effects.
  always_comb begin
    wb_en_s   = 1'b0;
    wb_data_s = 32'd0;
    is_ld_s   = 1'b0;
    is_st_s   = 1'b0;
    is_out_s  = 1'b0;
    is_halt_s = 1'b0;
    pc_d      = pc_q + 8'd1;
    case (op_s)
      OP_NOP:  begin wb_en_s = 1'b0; end
      OP_LDI:  begin wb_en_s = 1'b1; wb_data_s = {{16{imm_s[15]}}, imm_s}; end
      OP_LDIH: begin wb_en_s = 1'b1; wb_data_s = {imm_s, rd_s[15:0]}; end
      OP_ADD:  begin wb_en_s = 1'b1; wb_data_s = ra_s + rb_s; end
      OP_SUB:  begin wb_en_s = 1'b1; wb_data_s = ra_s - rb_s; end
      OP_AND:  begin wb_en_s = 1'b1; wb_data_s = ra_s & rb_s; end
      OP_OR:   begin wb_en_s = 1'b1; wb_data_s = ra_s | rb_s; end
      OP_XOR:  begin wb_en_s = 1'b1; wb_data_s = ra_s ^ rb_s; end
      OP_ADDI: begin wb_en_s = 1'b1; wb_data_s = ra_s + {{20{imm_s[11]}}, imm_s[11:0]}; end
      OP_SHL:  begin wb_en_s = 1'b1; wb_data_s = ra_s << rb_s[4:0]; end
      OP_SHR:  begin wb_en_s = 1'b1; wb_data_s = ra_s >> rb_s[4:0]; end
      OP_LD:   begin is_ld_s = 1'b1; end
      OP_ST:   begin is_st_s = 1'b1; end
      OP_IN:   begin wb_en_s = 1'b1; wb_data_s = port_in; end
      OP_OUT:  begin is_out_s = 1'b1; end
      OP_JMP:  begin pc_d = imm_s[7:0]; end
      OP_BZ: begin
        if (rd_s == 32'd0) begin
          pc_d = imm_s[7:0];
        end else begin
          pc_d = pc_q + 8'd1;
        end
      end
      OP_BNZ: begin
        if (rd_s != 32'd0) begin
          pc_d = imm_s[7:0];
        end else begin
          pc_d = pc_q + 8'd1;
        end
      end
      OP_MUL: begin
`ifdef SC1_CPU_MUL_EN
        wb_en_s   = 1'b1;
        wb_data_s = ra_s * rb_s;
`else
        wb_en_s   = 1'b0;
        wb_data_s = 32'd0;
`endif
      end
      OP_HALT: begin is_halt_s = 1'b1; end
      default: begin wb_en_s = 1'b0; end
    endcase
  end

  // Control FSM with PC, IR, register file and output port. Operands are
  // read from the old register values, so rd = f(rd, ...) sees the value
  // from before the instruction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_FETCH;
      pc_q       <= 8'd0;
      ir_q       <= 32'd0;
      port_out_q <= 32'd0;
      for (int i = 0; i < 16; i++) begin
        reg_file[i] <= 32'd0;
      end
    end else begin
      case (state_q)
        ST_FETCH: begin
          state_q <= ST_DECODE;
        end
        ST_DECODE: begin
          ir_q    <= rom_data;
          state_q <= ST_EXEC;
        end
        ST_EXEC: begin
          if (is_halt_s) begin
            state_q <= ST_HALTED;
          end else begin
            pc_q <= pc_d;
            if (wb_en_s) begin
              reg_file[d_s] <= wb_data_s;
            end
            if (is_out_s) begin
              port_out_q <= rd_s;
            end
            state_q <= is_ld_s ? ST_MEM : ST_FETCH;
          end
        end
        ST_MEM: begin
          reg_file[d_s] <= ram_rdata_s;
          state_q       <= ST_FETCH;
        end
        ST_HALTED: begin
          state_q <= ST_HALTED;
        end
        default: begin
          state_q <= ST_FETCH;
        end
      endcase
    end
  end

  assign rom_addr = pc_q;
  assign port_out = port_out_q;

endmodule

// File: tb/tb_sc1_cpu.sv
// Directed self-checking bench for sc1_cpu. A synchronous ROM model feeds
// short programs; expected PC / port values are hand-computed per edge.
module tb_sc1_cpu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rom_addr;
  logic [31:0] rom_data = 32'd0;
  logic [31:0] port_in = 32'hA5A5_5A5A;
  logic [31:0] port_out;

  logic [31:0] rom [0:255];
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  localparam logic [4:0] OP_LDI = 5'd1, OP_LDIH = 5'd2, OP_ADD = 5'd3,
    OP_SUB = 5'd4, OP_AND = 5'd5, OP_OR = 5'd6, OP_XOR = 5'd7,
    OP_ADDI = 5'd8, OP_SHL = 5'd9, OP_SHR = 5'd10, OP_LD = 5'd11,
    OP_ST = 5'd12, OP_IN = 5'd13, OP_OUT = 5'd14, OP_JMP = 5'd15,
    OP_BZ = 5'd16, OP_BNZ = 5'd17, OP_MUL = 5'd18, OP_HALT = 5'd31;

  sc1_cpu dut (
    .clk      (clk),
    .reset    (reset),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .port_in  (port_in),
    .port_out (port_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  function automatic logic [31:0] enc(input logic [4:0] op, input logic [3:0] d,
                                      input logic [3:0] a, input logic [15:0] imm);
    enc = {op, 3'b000, d, a, imm};
  endfunction

  function automatic logic [31:0] rrr(input logic [4:0] op, input logic [3:0] d,
                                      input logic [3:0] a, input logic [3:0] b);
    rrr = enc(op, d, a, {b, 12'h000});
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Hold reset low for 2 clk and clear the ROM to NOPs.
  task automatic hold_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 256; i++) rom[i] = 32'd0;
  endtask

  task automatic release_reset();
    reset = 1'b1;
    cyc = 0;
  endtask

  // Advance to the negedge following rising edge n after release.
  task automatic adv(input int n);
    while (cyc < n) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  typedef struct { int edge_n; logic [31:0] val; } exp_t;
  exp_t alu_exp [9];

  initial begin
    // ---------------- reset and fetch sequence ----------------
    hold_reset();
    chk("rst_rom_addr", {24'd0, rom_addr}, 32'd0);
    chk("rst_port_out", port_out, 32'd0);
    release_reset();
    for (int i = 0; i <= 8; i++) begin
      adv(i);
      chk("fetch_seq", {24'd0, rom_addr}, 32'(i / 3));
    end

    // ---------------- counter loop ----------------
    hold_reset();
    rom[0] = enc(OP_LDI, 4'd1, 4'd0, 16'd0);
    rom[1] = enc(OP_LDI, 4'd2, 4'd0, 16'd1);
    rom[2] = rrr(OP_ADD, 4'd1, 4'd1, 4'd2);
    rom[3] = enc(OP_OUT, 4'd1, 4'd0, 16'd0);
    rom[4] = enc(OP_JMP, 4'd0, 4'd0, 16'd2);
    release_reset();
    adv(11); chk("cnt_before", port_out, 32'd0);
    adv(12); chk("cnt_1", port_out, 32'd1);
    adv(20); chk("cnt_hold", port_out, 32'd1);
    adv(21); chk("cnt_2", port_out, 32'd2);
    adv(30); chk("cnt_3", port_out, 32'd3);
    // Reset in the middle of the loop clears port and PC.
    hold_reset();
    chk("midrst_port_out", port_out, 32'd0);
    chk("midrst_rom_addr", {24'd0, rom_addr}, 32'd0);

    // ---------------- memory ----------------
    rom[0] = enc(OP_LDI, 4'd3, 4'd0, 16'd5);
    rom[1] = enc(OP_LDI, 4'd4, 4'd0, 16'h1234);
    rom[2] = enc(OP_ST, 4'd4, 4'd3, 16'd0);
    rom[3] = enc(OP_LD, 4'd5, 4'd3, 16'd0);
    rom[4] = enc(OP_OUT, 4'd5, 4'd0, 16'd0);
    rom[5] = enc(OP_HALT, 4'd0, 4'd0, 16'd0);
    release_reset();
    adv(12); chk("ld_pc_exec", {24'd0, rom_addr}, 32'd4);
    adv(15); chk("ld_4clk_out_pending", port_out, 32'd0);
    adv(16); chk("ld_data", port_out, 32'h0000_1234);
    adv(25); chk("halt_pc", {24'd0, rom_addr}, 32'd5);

    // ---------------- branches ----------------
    hold_reset();
    rom[0]  = enc(OP_LDI, 4'd6, 4'd0, 16'd0);
    rom[1]  = enc(OP_BZ, 4'd6, 4'd0, 16'd10);
    rom[10] = enc(OP_LDI, 4'd6, 4'd0, 16'd1);
    rom[11] = enc(OP_BZ, 4'd6, 4'd0, 16'd10);
    rom[12] = enc(OP_BNZ, 4'd6, 4'd0, 16'd20);
    rom[20] = enc(OP_HALT, 4'd0, 4'd0, 16'd0);
    release_reset();
    adv(6);  chk("bz_taken", {24'd0, rom_addr}, 32'd10);
    adv(12); chk("bz_not_taken", {24'd0, rom_addr}, 32'd12);
    adv(15); chk("bnz_taken", {24'd0, rom_addr}, 32'd20);
    adv(24); chk("halt_pc_br", {24'd0, rom_addr}, 32'd20);

    // ---------------- LDI / LDIH / wrap-around add ----------------
    hold_reset();
    rom[0] = enc(OP_LDI, 4'd7, 4'd0, 16'hFFFF);
    rom[1] = enc(OP_OUT, 4'd7, 4'd0, 16'd0);
    rom[2] = enc(OP_LDIH, 4'd7, 4'd0, 16'h0001);
    rom[3] = enc(OP_OUT, 4'd7, 4'd0, 16'd0);
    rom[4] = enc(OP_LDI, 4'd8, 4'd0, 16'hFFFF);
    rom[5] = enc(OP_LDI, 4'd9, 4'd0, 16'd1);
    rom[6] = rrr(OP_ADD, 4'd10, 4'd8, 4'd9);
    rom[7] = enc(OP_OUT, 4'd10, 4'd0, 16'd0);
    rom[8] = rrr(OP_ADD, 4'd7, 4'd7, 4'd7);
    rom[9] = enc(OP_OUT, 4'd7, 4'd0, 16'd0);
    rom[10] = enc(OP_HALT, 4'd0, 4'd0, 16'd0);
    release_reset();
    adv(6);  chk("ldi_sext", port_out, 32'hFFFF_FFFF);
    adv(12); chk("ldih", port_out, 32'h0001_FFFF);
    adv(24); chk("add_wrap", port_out, 32'd0);
    adv(30); chk("add_self", port_out, 32'h0003_FFFE);

    // ---------------- ALU and IN ----------------
    hold_reset();
    rom[0]  = enc(OP_LDI, 4'd1, 4'd0, 16'h0F0F);
    rom[1]  = enc(OP_LDI, 4'd2, 4'd0, 16'h00FF);
    rom[2]  = rrr(OP_SUB, 4'd3, 4'd1, 4'd2);
    rom[3]  = enc(OP_OUT, 4'd3, 4'd0, 16'd0);
    rom[4]  = rrr(OP_AND, 4'd3, 4'd1, 4'd2);
    rom[5]  = enc(OP_OUT, 4'd3, 4'd0, 16'd0);
    rom[6]  = rrr(OP_OR, 4'd3, 4'd1, 4'd2);
    rom[7]  = enc(OP_OUT, 4'd3, 4'd0, 16'd0);
    rom[8]  = rrr(OP_XOR, 4'd3, 4'd1, 4'd2);
    rom[9]  = enc(OP_OUT, 4'd3, 4'd0, 16'd0);
    rom[10] = enc(OP_LDI, 4'd4, 4'd0, 16'd4);
    rom[11] = rrr(OP_SHL, 4'd3, 4'd1, 4'd4);
    rom[12] = enc(OP_OUT, 4'd3, 4'd0, 16'd0);
    rom[13] = enc(OP_LDI, 4'd5, 4'd0, 16'h8000);
    rom[14] = rrr(OP_SHR, 4'd3, 4'd5, 4'd4);
    rom[15] = enc(OP_OUT, 4'd3, 4'd0, 16'd0);
    rom[16] = enc(OP_ADDI, 4'd3, 4'd2, 16'h0FFF);
    rom[17] = enc(OP_OUT, 4'd3, 4'd0, 16'd0);
    rom[18] = rrr(OP_SUB, 4'd3, 4'd2, 4'd1);
    rom[19] = enc(OP_OUT, 4'd3, 4'd0, 16'd0);
    rom[20] = enc(OP_IN, 4'd3, 4'd0, 16'd0);
    rom[21] = enc(OP_OUT, 4'd3, 4'd0, 16'd0);
    rom[22] = enc(OP_HALT, 4'd0, 4'd0, 16'd0);
    alu_exp[0] = '{12, 32'h0000_0E10};
    alu_exp[1] = '{18, 32'h0000_000F};
    alu_exp[2] = '{24, 32'h0000_0FFF};
    alu_exp[3] = '{30, 32'h0000_0FF0};
    alu_exp[4] = '{39, 32'h0000_F0F0};
    alu_exp[5] = '{48, 32'h0FFF_F800};
    alu_exp[6] = '{54, 32'h0000_00FE};
    alu_exp[7] = '{60, 32'hFFFF_F1F0};
    alu_exp[8] = '{66, 32'hA5A5_5A5A};
    release_reset();
    for (int i = 0; i < 9; i++) begin
      adv(alu_exp[i].edge_n);
      chk($sformatf("alu_%0d", i), port_out, alu_exp[i].val);
    end

    // ---------------- PC wrap 255 -> 0 ----------------
    hold_reset();
    rom[0]   = enc(OP_JMP, 4'd0, 4'd0, 16'd254);
    rom[254] = enc(OP_LDI, 4'd1, 4'd0, 16'h0055);
    rom[255] = enc(OP_OUT, 4'd1, 4'd0, 16'd0);
    release_reset();
    adv(6); chk("pc_255", {24'd0, rom_addr}, 32'd255);
    adv(9); chk("pc_wrap", {24'd0, rom_addr}, 32'd0);
    chk("wrap_out", port_out, 32'h0000_0055);

    // ---------------- MUL and HALT ----------------
    hold_reset();
    rom[0] = enc(OP_LDI, 4'd1, 4'd0, 16'd7);
    rom[1] = enc(OP_LDI, 4'd2, 4'd0, 16'd6);
    rom[2] = enc(OP_LDI, 4'd3, 4'd0, 16'd5);
    rom[3] = rrr(OP_MUL, 4'd3, 4'd1, 4'd2);
    rom[4] = enc(OP_OUT, 4'd3, 4'd0, 16'd0);
    rom[5] = enc(OP_HALT, 4'd0, 4'd0, 16'd0);
    release_reset();
`ifdef SC1_CPU_MUL_EN
    adv(15); chk("mul", port_out, 32'd42);
`else
    adv(15); chk("mul_nop", port_out, 32'd5);
`endif
    adv(18); chk("halt_enter", {24'd0, rom_addr}, 32'd5);
    adv(27); chk("halt_stay", {24'd0, rom_addr}, 32'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sc1_cpu.md
SC1_CPU -- requirements
Module: sc1_cpu

Interface
REQ-001 SHALL have parameter DMEM_AW, default 8, giving the data-memory address width (2^DMEM_AW words of 32 bits).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port rom_addr, output, 8 bits: instruction fetch address, equal to the current PC.
REQ-005 SHALL have port rom_data, input, 32 bits: instruction word from an external synchronous ROM, valid one clk after rom_addr.
REQ-006 SHALL have port port_in, input, 32 bits: general input port, sampled by IN.
REQ-007 SHALL have port port_out, output, 32 bits: registered output port, written by OUT.

Function
REQ-008 SHALL contain 16 x 32-bit registers r0..r15 (reg_file), all general purpose, and a 2^DMEM_AW x 32 synchronous data RAM instance named mem_d_a.
REQ-009 SHALL use instruction fields op=[31:27], d=[23:20], a=[19:16], b=[15:12], imm=[15:0]; a field not used by an opcode is ignored.
REQ-010 SHALL run a non-pipelined FSM: FETCH (rom_addr=PC) -> DECODE (latch rom_data into IR) -> EXEC -> FETCH; LD inserts MEM between EXEC and FETCH; HALT enters HALTED permanently.
REQ-011 SHALL take 3 clk per instruction (4 for LD); the branch decision and PC update occur in EXEC.
REQ-012 SHALL implement opcodes: 0 NOP; 1 LDI rd=sext(imm); 2 LDIH rd={imm,rd[15:0]}; 3 ADD; 4 SUB; 5 AND; 6 OR; 7 XOR (rd=ra op rb); 8 ADDI rd=ra+sext(imm[11:0]); 9 SHL rd=ra<<rb[4:0]; 10 SHR rd=ra>>rb[4:0] (logical).
REQ-013 SHALL implement opcodes: 11 LD rd=mem[ra[DMEM_AW-1:0]]; 12 ST mem[ra[DMEM_AW-1:0]]=rd; 13 IN rd=port_in; 14 OUT port_out=rd; 15 JMP PC=imm[7:0]; 16 BZ (if rd==0) PC=imm[7:0]; 17 BNZ (if rd!=0) PC=imm[7:0]; 18 MUL (see REQ-020); 31 HALT.
REQ-014 SHALL increment PC by 1 modulo 256 for every non-taken-branch instruction, so 255 wraps to 0.
REQ-015 SHALL perform all arithmetic modulo 2^32 with no flags, and SHALL treat undefined opcodes as NOP.
REQ-016 SHALL return, when an instruction reads the register it writes, the value from before that instruction (e.g. ADD r1,r1,r1 doubles r1).

Reset
REQ-017 SHALL, while reset is low, asynchronously force PC=0, state=FETCH, IR=0, port_out=0 and r0..r15=0; data RAM contents are not reset.
REQ-018 SHALL, after reset is released, fetch address 0 on the first rising edge of clk; a reset asserted mid-instruction SHALL abort that instruction with no register, memory or port write.

Configuration
REQ-019 SHALL use macro SC1_CPU_MUL_EN to include or exclude the multiplier.
REQ-020 SHALL, with SC1_CPU_MUL_EN defined, execute opcode 18 as rd=low 32 bits of ra*rb in 3 clk; without it, opcode 18 SHALL behave as NOP and no multiplier SHALL be synthesized.

Verification
REQ-021 SHALL cover reset: hold reset low 2 clk -> rom_addr=0 and port_out=0; after release, rom_addr=0,1,2 on consecutive FETCH states 3 clk apart.
REQ-022 SHALL cover a counter loop: LDI r1,0; LDI r2,1; L: ADD r1,r1,r2; OUT r1; JMP L -> port_out reads 1,2,3,... with one increment every 9 clk.
REQ-023 SHALL cover memory: LDI r3,5; LDI r4,0x1234; ST r4,[r3]; LD r5,[r3]; OUT r5 -> port_out=0x00001234, and the LD takes 4 clk.
REQ-024 SHALL cover branches: LDI r6,0; BZ r6,10 -> next fetch at 10; LDI r6,1; BZ r6,10 -> next fetch at PC+1; BNZ r6,20 -> next fetch at 20.
REQ-025 SHALL cover LDI and LDIH: LDI r7,0xFFFF -> r7=0xFFFFFFFF; LDIH r7,0x0001 -> r7=0x0001FFFF; ADD with 0xFFFFFFFF+1 -> 0.
REQ-026 SHALL cover MUL and HALT: LDI 7 and 6 into two registers, MUL, OUT -> port_out=42 with SC1_CPU_MUL_EN defined, previous value without it; after HALT, rom_addr stays constant.
